// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALUop indices, opcode/funct encodings and decode bundle type
package alu_pkg;

  localparam int OP_WIDTH   = 12;
  localparam int DATA_WIDTH = 32;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_NOR  = 4;
  localparam int OP_XOR  = 5;
  localparam int OP_SLT  = 6;
  localparam int OP_SLTU = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   aluop;
    logic                  a_shamt;
    logic                  b_imm;
    logic [DATA_WIDTH-1:0] imm;
    logic                  illegal;
  } dec_bundle_t;

  function automatic logic [OP_WIDTH-1:0] onehot(input int idx);
    return OP_WIDTH'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_op_dec_comb.sv
// rtl/alu_op_dec_comb.sv - combinational MIPS instruction to decode bundle
module alu_op_dec_comb
  import alu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] inst_i,
  output dec_bundle_t           bundle_o
);

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] simm;
  logic [DATA_WIDTH-1:0] zimm;

  assign opcode = inst_i[31:26];
  assign funct  = inst_i[5:0];
  assign simm   = {{16{inst_i[15]}}, inst_i[15:0]};
  assign zimm   = {16'b0, inst_i[15:0]};

  always_comb begin
    bundle_o = '0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: bundle_o.aluop = onehot(OP_ADD);
          FN_SUB, FN_SUBU: bundle_o.aluop = onehot(OP_SUB);
          FN_AND:          bundle_o.aluop = onehot(OP_AND);
          FN_OR:           bundle_o.aluop = onehot(OP_OR);
          FN_XOR:          bundle_o.aluop = onehot(OP_XOR);
          FN_NOR:          bundle_o.aluop = onehot(OP_NOR);
          FN_SLT:          bundle_o.aluop = onehot(OP_SLT);
          FN_SLTU:         bundle_o.aluop = onehot(OP_SLTU);
          FN_SLL: begin bundle_o.aluop = onehot(OP_SLL); bundle_o.a_shamt = 1'b1; end
          FN_SRL: begin bundle_o.aluop = onehot(OP_SRL); bundle_o.a_shamt = 1'b1; end
          FN_SRA: begin bundle_o.aluop = onehot(OP_SRA); bundle_o.a_shamt = 1'b1; end
          FN_SLLV:         bundle_o.aluop = onehot(OP_SLL);
          FN_SRLV:         bundle_o.aluop = onehot(OP_SRL);
          FN_SRAV:         bundle_o.aluop = onehot(OP_SRA);
          default:         bundle_o.illegal = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
        bundle_o.aluop = onehot(OP_ADD);  bundle_o.b_imm = 1'b1; bundle_o.imm = simm;
      end
      OPC_SLTI: begin
        bundle_o.aluop = onehot(OP_SLT);  bundle_o.b_imm = 1'b1; bundle_o.imm = simm;
      end
      OPC_SLTIU: begin
        bundle_o.aluop = onehot(OP_SLTU); bundle_o.b_imm = 1'b1; bundle_o.imm = simm;
      end
      OPC_ANDI: begin
        bundle_o.aluop = onehot(OP_AND);  bundle_o.b_imm = 1'b1; bundle_o.imm = zimm;
      end
      OPC_ORI: begin
        bundle_o.aluop = onehot(OP_OR);   bundle_o.b_imm = 1'b1; bundle_o.imm = zimm;
      end
      OPC_XORI: begin
        bundle_o.aluop = onehot(OP_XOR);  bundle_o.b_imm = 1'b1; bundle_o.imm = zimm;
      end
      OPC_LUI: begin
        bundle_o.aluop = onehot(OP_LUI);  bundle_o.b_imm = 1'b1; bundle_o.imm = zimm;
      end
      default: bundle_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - skid-buffered ALUop decoder; ALU_DEC_STAT_EN enables stat counters
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH-1:0]   out_aluop,
  output logic                  out_a_shamt,
  output logic                  out_b_imm,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_illegal,
  output logic [31:0]           stat_accepted,
  output logic [31:0]           stat_illegal
);

  dec_bundle_t dec;
  dec_bundle_t main_q, main_d;
  dec_bundle_t skid_q, skid_d;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        accept;
  logic        drain;

  alu_op_dec_comb u_dec (
    .inst_i   (in_inst),
    .bundle_o (dec)
  );

  assign accept = in_valid & in_ready_q & ~flush;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_d       = '0;
      skid_d       = '0;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-main promotion can happen
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      main_valid_d = accept;
      if (accept) main_d = dec;
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_aluop   = main_q.aluop;
  assign out_a_shamt = main_q.a_shamt;
  assign out_b_imm   = main_q.b_imm;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;

`ifdef ALU_DEC_STAT_EN
  logic [31:0] acc_cnt_q, acc_cnt_d;
  logic [31:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q + {31'b0, accept};
    ill_cnt_d = ill_cnt_q + {31'b0, accept & dec.illegal};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q <= '0;
      ill_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign stat_accepted = acc_cnt_q;
  assign stat_illegal  = ill_cnt_q;
`else
  assign stat_accepted = '0;
  assign stat_illegal  = '0;
`endif

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Decode-side producer of the 12-bit one-hot ALUop bus and operand selects consumed by the single-cycle ALU.
- Takes 32-bit MIPS instruction words over valid/ready and emits registered decode bundles over valid/ready.
- Uses a 2-entry skid buffer so in_ready is a registered signal, and sits between fetch and the execute datapath of the multi-cycle/pipelined CPU.

Parameters:
- OP_WIDTH, 12, ALUop width; bit order add,sub,and,or,nor,xor,slt,sltu,sll,srl,sra,lui = bits 0..11.
- DATA_WIDTH, 32, instruction and immediate width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  instruction valid.
- in_ready  out  1  decoder can accept; registered.
- in_inst  in  32  MIPS instruction word.
- out_valid  out  1  decode bundle valid.
- out_ready  in  1  downstream accepts.
- out_aluop  out  12  one-hot ALUop; all-zero for illegal.
- out_a_shamt  out  1  1: ALU A = zero-extended inst[10:6]; 0: A = rs.
- out_b_imm  out  1  1: ALU B = out_imm; 0: B = rt.
- out_imm  out  32  extended immediate.
- out_illegal  out  1  opcode/funct not in the decode table.
- stat_accepted  out  32  accepted-instruction count (optional feature).
- stat_illegal  out  32  illegal-instruction count (optional feature).

Behaviour:
- Reset: out_valid=0, in_ready=1, entries empty, out_aluop=0, out_imm=0, flags=0, counters=0.
- Decode is combinational on in_inst; the result is captured into the buffer on accept (in_valid & in_ready).
- Latency: 1 cycle from accept to out_valid when the buffer is empty.
- Throughput: 1 instruction per cycle with out_ready held high.
- Buffer structure: main register drives the outputs; skid register captures one extra bundle when out_ready drops.
  - in_ready = ~skid_full, registered.
  - On out_ready, skid contents move to main in the same edge.
- Ordering: strictly FIFO; outputs stay stable while out_valid & ~out_ready.
- Full: with main and skid both occupied, in_ready=0 and in_valid is ignored.
- Simultaneous accept and drain of the single main entry: the new bundle goes directly into main; skid stays empty.
- flush: next edge clears both entries, out_valid=0, in_ready=1. An in_valid in the same cycle is dropped and not counted. flush has priority over all handshakes.
- Reset mid-transfer: any buffered bundles are lost; outputs return to reset values immediately (asynchronous).
- R-type decode (opcode 000000), by funct:
  - 100000/100001 -> add
  - 100010/100011 -> sub
  - 100100 and; 100101 or; 100110 xor; 100111 nor
  - 101010 slt; 101011 sltu
  - 000000 sll, 000010 srl, 000011 sra, with a_shamt=1
  - 000100 sllv, 000110 srlv, 000111 srav, with a_shamt=0
- I-type decode, b_imm=1:
  - 001000/001001 add, sign-extended
  - 001010 slt, sign-extended
  - 001011 sltu, sign-extended
  - 001100 and, zero-extended
  - 001101 or, zero-extended
  - 001110 xor, zero-extended
  - 001111 lui, out_imm={16'b0, imm16}
  - 100011/101011 (lw/sw) add, sign-extended
- R-type: out_imm=0, b_imm=0.
- Any other encoding: illegal=1, aluop=0, a_shamt=0, b_imm=0, imm=0. The bundle still flows; it is not dropped.
- Invariant: popcount(out_aluop) <= 1 whenever out_valid.

Optional Feature:
- Macro: ALU_DEC_STAT_EN.
- Defined:
  - stat_accepted increments on each accepted, non-flushed instruction.
  - stat_illegal increments on each such instruction that decodes illegal.
  - Both counters wrap modulo 2^32; reset to 0 on rst only, not on flush.
- Undefined: both stat outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package alu_pkg:
  - ALUop bit indices and OP_WIDTH.
  - opcode/funct localparams.
  - decode bundle struct {aluop, a_shamt, b_imm, imm, illegal}.
- Sub-module alu_op_dec_comb: pure combinational inst -> bundle.
- Top holds the skid buffer, handshake and counters.

Test Plan:
- Reset, then in_inst=0x00851020 (add $2,$4,$5) with out_ready=1 -> next cycle out_valid=1, aluop=12'h001, b_imm=0, a_shamt=0, illegal=0.
- in_inst=0x2408FFFF (addiu) -> aluop=12'h001, b_imm=1, imm=0xFFFFFFFF. Then 0x3408FFFF (ori) -> aluop=12'h008, imm=0x0000FFFF.
- in_inst=0x00041080 (sll $2,$4,2) -> aluop=12'h100, a_shamt=1. Then 0x3C011234 (lui) -> aluop=12'h800, imm=0x00001234.
- out_ready=0 while sending 3 back-to-back valids -> first two accepted, in_ready=0 on the third. Release out_ready -> outputs emerge in order, none lost or duplicated.
- in_inst=0xFC000000 -> illegal=1, aluop=0. With ALU_DEC_STAT_EN: stat_illegal=1, stat_accepted=1.
- Two entries buffered, then flush together with in_valid -> next cycle out_valid=0, in_ready=1, counters unchanged. Assert rst mid-stream -> outputs zero immediately.
